// File: rtl/slice_adder_seq.sv
// slice_adder_seq: WIDTH-bit add/subtract computed over WIDTH/SLICE cycles on one shared SLICE-bit ripple slice
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   operation handshake; a, b, cin, sub captured on acceptance
//   out_valid / out_ready result handshake; sum, cout, ovf held until the next result
//   busy                  high while an operation is running or waiting to be taken
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module slice_adder_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NSTEP = WIDTH / SLICE;
  localparam int SW    = NSTEP > 1 ? $clog2(NSTEP) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, nstate;
  logic [WIDTH-1:0] ra, rb, partial, np;
  logic [SW-1:0]    step;
  logic             carry, last;
  logic [SLICE-1:0] sa, sb, ss;
  logic [SLICE:0]   cc;
  assign sa    = ra[int'(step)*SLICE +: SLICE];
  assign sb    = rb[int'(step)*SLICE +: SLICE];
  assign cc[0] = carry;
  assign last  = step == SW'(NSTEP - 1);
  genvar i;
  generate
    for (i = 0; i < SLICE; i++) begin : g_fa
      full_adder u_fa (.a(sa[i]), .b(sb[i]), .ci(cc[i]), .s(ss[i]), .co(cc[i+1]));
    end
  endgenerate
  // partial with the current slice merged in; on the last step this is the full result
  always_comb begin
    np = partial;
    np[int'(step)*SLICE +: SLICE] = ss;
  end
  always_comb begin
    nstate = state == IDLE ? (in_valid ? RUN : IDLE) :
             state == RUN  ? (last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra      <= '0;
      rb      <= '0;
      partial <= '0;
      step    <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra    <= a;
      rb    <= b ^ {WIDTH{sub}};
      carry <= cin;
      step  <= '0;
    end else if (state == RUN) begin
      partial <= np;
      carry   <= cc[SLICE];
      step    <= step + 1'b1;
      if (last) begin
        sum  <= np;
        cout <= cc[SLICE];
        // cc[SLICE-1] is the carry into the MSB cell
        ovf  <= cc[SLICE] ^ cc[SLICE-1];
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_slice_adder_seq.sv
// tb_slice_adder_seq: scoreboard bench for slice_adder_seq
module tb_slice_adder_seq;
  localparam int W = 16;
  localparam int S = 4;
  localparam int NSTEP = W / S;
  typedef struct packed {logic ovf; logic cout; logic [W-1:0] sum;} res_t;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;
  res_t q[$];
  res_t r;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = -1000, prev_acc = -1, n_acc = 0;
  bit b2b = 0;
  logic prev_ov = 0;
  always #5 clk = ~clk;
  slice_adder_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0] t;
    res_t m;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
    m.sum = t[W-1:0];
    m.cout = t[W];
    m.ovf = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return m;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_ov = 0;
      prev_acc = -1;
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        if (b2b && prev_acc >= 0) check("spacing", cyc - prev_acc, NSTEP + 2);
        prev_acc = b2b ? cyc : -1;
        acc_cyc = cyc;
        n_acc++;
      end
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc - 1, NSTEP);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          r = q.pop_front();
          check("sum", sum, r.sum);
          check("cout", cout, r.cout);
          check("ovf", ovf, r.ovf);
        end
      end
      prev_ov = out_valid;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int t = 0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (t == 50) check("accept_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy) && t < 100) begin tick(); t++; end
    if (t == 100) check("drain_timeout", 0, 1);
  endtask
  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    send(x, y, ci, s);
    drain();
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    int t, start;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    send(16'hFFFF, 16'h0001, 0, 0);
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    drain();
    check("ripple_sum", sum, 16'h0000);
    check("ripple_cout", cout, 1);
    check("ripple_ovf", ovf, 0);
    directed("ovf_pos", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    directed("ovf_neg", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    directed("borrow", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    directed("noborrow", 16'h0007, 16'h0005, 1, 1, 16'h0002, 1, 0);
    directed("cin_add", 16'h00FF, 16'h0F00, 1, 0, 16'h1000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      drain();
    end
    out_ready = 0;
    send(16'h1234, 16'h4321, 0, 0);
    t = 0;
    while (!out_valid && t < 20) begin tick(); t++; end
    if (t == 20) check("bp_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
      tick();
      check("bp_sum", sum, 16'h5555);
      check("bp_cout", cout, 0);
      check("bp_ovf", ovf, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("idle_after_ack", in_ready, 1);
    a = 16'h0101; b = 16'h0202; cin = 0; sub = 0;
    b2b = 1;
    in_valid = 1;
    start = n_acc;
    t = 0;
    while (n_acc < start + 3 && t < 100) begin tick(); t++; end
    if (t == 100) check("b2b_timeout", 0, 1);
    in_valid = 0;
    b2b = 0;
    drain();
    check("b2b_sum", sum, 16'h0303);
    send(16'hAAAA, 16'h5555, 0, 0);
    tick();
    rst_n = 0;
    tick();
    check("mrst_sum", sum, 0);
    check("mrst_cout", cout, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_out_after_rst", out_valid, 0);
    end
    directed("post_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
